// File: rtl/rgb_pixel_aligner.sv
// Re-aligns three independently timed 8-bit colour streams into 24-bit pixels.
// Each channel has its own FIFO; the output register uses a valid/ready handshake and frame completion is reported.
module rgb_pixel_aligner #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       valid,
    input  logic [2:0]       done,
    input  logic [7:0]       R,
    input  logic [7:0]       G,
    input  logic [7:0]       B,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [23:0]      pix_rgb,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_pixels,
    output logic [2:0]       overflow
);

    typedef enum logic [0:0] {
        STREAM = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [7:0]       mem_r     [3][DEPTH];
    logic [AW-1:0]    wr_ptr_r  [3];
    logic [AW-1:0]    rd_ptr_r  [3];
    logic [AW:0]      cnt_r     [3];
    logic [7:0]       din_s     [3];
    logic [2:0]       wr_s;
    logic [2:0]       ovf_s;
    logic             pop_s;
    logic             hs_s;
    logic             all_empty_s;
    logic             all_done_s;
    logic             end_ok_s;
    logic             fire_s;
    logic [23:0]      head_s;
    logic [2:0]       latch_r;
    logic [CNT_W-1:0] pix_cnt_r;
    logic [CNT_W-1:0] pix_cnt_nxt_s;
    state_t           state_r;
    state_t           state_s;

    // Write/pop qualification; pops only see registered counts, so a write into an empty FIFO is not bypassed
    always_comb begin
        din_s[0]    = R;
        din_s[1]    = G;
        din_s[2]    = B;
        wr_s        = 3'b000;
        ovf_s       = 3'b000;
        pop_s       = (cnt_r[0] != '0) && (cnt_r[1] != '0) && (cnt_r[2] != '0) &&
                      (!pix_valid || pix_ready);
        hs_s        = pix_valid & pix_ready;
        all_empty_s = (cnt_r[0] == '0) && (cnt_r[1] == '0) && (cnt_r[2] == '0);
        all_done_s  = &latch_r;
        end_ok_s    = all_done_s && all_empty_s && (!pix_valid || pix_ready);
        head_s      = {mem_r[0][rd_ptr_r[0]], mem_r[1][rd_ptr_r[1]], mem_r[2][rd_ptr_r[2]]};
        pix_cnt_nxt_s = pix_cnt_r + {{(CNT_W-1){1'b0}}, hs_s};
        for (int i = 0; i < 3; i++) begin
            wr_s[i]  = valid[i] && ((cnt_r[i] != FULL) || pop_s);
            ovf_s[i] = valid[i] && (cnt_r[i] == FULL) && !pop_s;
        end
    end

    // FIFO storage; contents need no reset because counts gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr_s[i] && !rst) begin
                mem_r[i][wr_ptr_r[i]] <= din_s[i];
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                cnt_r[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wr_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + 1'b1;
                end
                if (pop_s) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + 1'b1;
                end
                case ({wr_s[i], pop_s})
                    2'b10:   cnt_r[i] <= cnt_r[i] + 1'b1;
                    2'b01:   cnt_r[i] <= cnt_r[i] - 1'b1;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Output pixel register with hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_rgb   <= 24'h000000;
        end else if (pop_s) begin
            pix_valid <= 1'b1;
            pix_rgb   <= head_s;
        end else if (pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

    // Frame FSM: FLUSH waits for buffered pixels to drain once every channel has signalled done
    always_comb begin
        state_s = state_r;
        fire_s  = 1'b0;
        case (state_r)
            STREAM: begin
                if (all_done_s) begin
                    if (end_ok_s) begin
                        fire_s = 1'b1;
                    end else begin
                        state_s = FLUSH;
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            FLUSH: begin
                if (end_ok_s) begin
                    fire_s  = 1'b1;
                    state_s = STREAM;
                end else begin
                    state_s = FLUSH;
                end
            end
            default: state_s = STREAM;
        endcase
    end

    // Frame bookkeeping: done latches (set beats clear), pixel counting, sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= STREAM;
            latch_r      <= 3'b000;
            pix_cnt_r    <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            overflow     <= 3'b000;
        end else begin
            state_r    <= state_s;
            frame_done <= fire_s;
            latch_r    <= (fire_s ? 3'b000 : latch_r) | done;
            overflow   <= overflow | ovf_s;
            if (fire_s) begin
                frame_pixels <= pix_cnt_nxt_s;
                pix_cnt_r    <= '0;
            end else begin
                pix_cnt_r    <= pix_cnt_nxt_s;
            end
        end
    end

endmodule
